// File: rtl/seq_impl_checker.sv
// Multi-channel checker for (a && b) ##ANT_GAP c |-> ##CONS_DLY !d with overlapping
// attempts, per-channel pass/fail pulses, saturating counters and sticky error capture.
module seq_impl_checker #(
   parameter int NUM_CH   = 4,
   parameter int ANT_GAP  = 1,
   parameter int CONS_DLY = 2,
   parameter int NONOVL   = 0,
   parameter int CNT_W    = 16,
   localparam int FCH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_clr,
   input  logic [NUM_CH-1:0] i_a,
   input  logic [NUM_CH-1:0] i_b,
   input  logic [NUM_CH-1:0] i_c,
   input  logic [NUM_CH-1:0] i_d,
   output logic [NUM_CH-1:0] o_pass,
   output logic [NUM_CH-1:0] o_fail,
   output logic [NUM_CH-1:0] o_fail_sticky,
   output logic              o_err,
   output logic [FCH_W-1:0]  o_first_fail_ch,
   output logic [CNT_W-1:0]  o_pass_cnt,
   output logic [CNT_W-1:0]  o_fail_cnt,
   output logic [CNT_W-1:0]  o_vac_cnt
);

   localparam int MLEN  = NONOVL + CONS_DLY;
   localparam int SUM_W = CNT_W + 6;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
      $error("seq_impl_checker: NUM_CH must be in 1..32");
   end
   if (ANT_GAP < 1) begin : g_bad_ant_gap
      $error("seq_impl_checker: ANT_GAP must be >= 1");
   end
   if (CONS_DLY < 0) begin : g_bad_cons_dly
      $error("seq_impl_checker: CONS_DLY must be >= 0");
   end
   if (NONOVL != 0 && NONOVL != 1) begin : g_bad_nonovl
      $error("seq_impl_checker: NONOVL must be 0 or 1");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("seq_impl_checker: CNT_W must be >= 1");
   end

   function automatic logic [5:0] f_popcount(input logic [NUM_CH-1:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < NUM_CH; i++) n = n + 6'(v[i]);
      return n;
   endfunction

   // Sum is formed wider than the counter so the clamp is exact for any popcount.
   function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] cnt,
                                                  input logic [5:0]       inc);
      logic [SUM_W-1:0] sum;
      logic [CNT_W-1:0] res;
      sum = SUM_W'(cnt) + SUM_W'(inc);
      if (sum > SUM_W'(CNT_MAX)) res = CNT_MAX;
      else                       res = sum[CNT_W-1:0];
      return res;
   endfunction

   function automatic logic [FCH_W-1:0] f_lowest(input logic [NUM_CH-1:0] v);
      logic [FCH_W-1:0] idx;
      idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (v[i]) idx = FCH_W'(i);
      end
      return idx;
   endfunction

   logic [NUM_CH-1:0] w_pass;
   logic [NUM_CH-1:0] w_fail;
   logic [NUM_CH-1:0] w_vac;

   // Each attempt occupies one slot of a shift pipeline, so any number may overlap.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [ANT_GAP-1:0] r_st;
      logic               w_start;
      logic               w_ant;
      logic               w_match;
      logic               w_chk;

      assign w_start = i_en & i_a[g] & i_b[g];
      assign w_ant   = r_st[ANT_GAP-1];
      assign w_match = w_ant & i_c[g];

      always_ff @(posedge i_clk) begin
         if (i_rst) r_st <= '0;
         else       r_st <= (r_st << 1) | ANT_GAP'(w_start);
      end

      if (MLEN > 0) begin : g_mt
         logic [MLEN-1:0] r_mt;
         always_ff @(posedge i_clk) begin
            if (i_rst) r_mt <= '0;
            else       r_mt <= (r_mt << 1) | MLEN'(w_match);
         end
         assign w_chk = r_mt[MLEN-1];
      end else begin : g_nomt
         assign w_chk = w_match;
      end

      assign w_pass[g] = w_chk & ~i_d[g];
      assign w_fail[g] = w_chk &  i_d[g];
      assign w_vac[g]  = w_ant & ~i_c[g];
   end

   logic [NUM_CH-1:0] r_pass;
   logic [NUM_CH-1:0] r_fail;
   logic [NUM_CH-1:0] r_sticky;
   logic [FCH_W-1:0]  r_ffc;
   logic [CNT_W-1:0]  r_pcnt;
   logic [CNT_W-1:0]  r_fcnt;
   logic [CNT_W-1:0]  r_vcnt;

   // Pulses always reflect the deciding edge; clr only suppresses the bookkeeping.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pass   <= '0;
         r_fail   <= '0;
         r_sticky <= '0;
         r_ffc    <= '0;
         r_pcnt   <= '0;
         r_fcnt   <= '0;
         r_vcnt   <= '0;
      end else begin
         r_pass <= w_pass;
         r_fail <= w_fail;
         if (i_clr) begin
            r_sticky <= '0;
            r_ffc    <= '0;
            r_pcnt   <= '0;
            r_fcnt   <= '0;
            r_vcnt   <= '0;
         end else begin
            r_pcnt   <= f_sat_add(r_pcnt, f_popcount(w_pass));
            r_fcnt   <= f_sat_add(r_fcnt, f_popcount(w_fail));
            r_vcnt   <= f_sat_add(r_vcnt, f_popcount(w_vac));
            r_sticky <= r_sticky | w_fail;
            if (!(|r_sticky) && (|w_fail)) r_ffc <= f_lowest(w_fail);
         end
      end
   end

   assign o_pass          = r_pass;
   assign o_fail          = r_fail;
   assign o_fail_sticky   = r_sticky;
   assign o_err           = |r_sticky;
   assign o_first_fail_ch = r_ffc;
   assign o_pass_cnt      = r_pcnt;
   assign o_fail_cnt      = r_fcnt;
   assign o_vac_cnt       = r_vcnt;

endmodule

// File: tb/tb_seq_impl_checker.sv
// Bench for seq_impl_checker: directed scenarios plus random traffic, checked against an
// input-history model for an overlapped/16-bit instance and a non-overlapped/2-bit instance.
module tb_seq_impl_checker;

   localparam int NCH  = 4;
   localparam int GAP  = 1;
   localparam int DLY  = 2;
   localparam int HMAX = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, en, clr;
   logic [NCH-1:0] a, b, c, d;

   logic [NCH-1:0] p0_pass, p0_fail, p0_stk;
   logic           p0_err;
   logic [1:0]     p0_ffc;
   logic [15:0]    p0_pc, p0_fc, p0_vc;
   logic [NCH-1:0] p1_pass, p1_fail, p1_stk;
   logic           p1_err;
   logic [1:0]     p1_ffc;
   logic [1:0]     p1_pc, p1_fc, p1_vc;

   seq_impl_checker #(.NUM_CH(NCH), .ANT_GAP(GAP), .CONS_DLY(DLY), .NONOVL(0), .CNT_W(16)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr),
      .i_a(a), .i_b(b), .i_c(c), .i_d(d),
      .o_pass(p0_pass), .o_fail(p0_fail), .o_fail_sticky(p0_stk), .o_err(p0_err),
      .o_first_fail_ch(p0_ffc), .o_pass_cnt(p0_pc), .o_fail_cnt(p0_fc), .o_vac_cnt(p0_vc)
   );

   seq_impl_checker #(.NUM_CH(NCH), .ANT_GAP(GAP), .CONS_DLY(DLY), .NONOVL(1), .CNT_W(2)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr),
      .i_a(a), .i_b(b), .i_c(c), .i_d(d),
      .o_pass(p1_pass), .o_fail(p1_fail), .o_fail_sticky(p1_stk), .o_err(p1_err),
      .o_first_fail_ch(p1_ffc), .o_pass_cnt(p1_pc), .o_fail_cnt(p1_fc), .o_vac_cnt(p1_vc)
   );

   // Input history by edge index; expected behaviour is derived from it directly.
   logic [NCH-1:0] h_start [HMAX];
   logic [NCH-1:0] h_c     [HMAX];
   logic           h_rst   [HMAX];
   int             e = 0;

   logic [NCH-1:0] m_pass [2];
   logic [NCH-1:0] m_fail [2];
   logic [NCH-1:0] m_stk  [2];
   int             m_ffc  [2];
   int             m_pc   [2];
   int             m_fc   [2];
   int             m_vc   [2];
   int             cmax   [2] = '{65535, 3};
   int             mlen   [2] = '{DLY, DLY + 1};

   int n_cmp = 0;
   int n_bad = 0;

   function automatic bit no_rst(input int k, input int t);
      for (int j = k; j <= t; j++) if (h_rst[j]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int lowest(input logic [NCH-1:0] v);
      for (int i = 0; i < NCH; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_step();
      logic [NCH-1:0] ep, ef, ev;
      int k;
      h_start[e] = en ? (a & b) : '0;
      h_c[e]     = c;
      h_rst[e]   = rst;
      for (int u = 0; u < 2; u++) begin
         ep = '0; ef = '0; ev = '0;
         for (int ch = 0; ch < NCH; ch++) begin
            k = e - GAP;
            if (k >= 0 && h_start[k][ch] && !c[ch] && no_rst(k, e)) ev[ch] = 1'b1;
            k = e - GAP - mlen[u];
            if (k >= 0 && h_start[k][ch] && h_c[k+GAP][ch] && no_rst(k, e)) begin
               if (d[ch]) ef[ch] = 1'b1;
               else       ep[ch] = 1'b1;
            end
         end
         if (rst) begin
            m_pass[u] = '0; m_fail[u] = '0; m_stk[u] = '0;
            m_ffc[u] = 0; m_pc[u] = 0; m_fc[u] = 0; m_vc[u] = 0;
         end else begin
            m_pass[u] = ep;
            m_fail[u] = ef;
            if (clr) begin
               m_stk[u] = '0; m_ffc[u] = 0; m_pc[u] = 0; m_fc[u] = 0; m_vc[u] = 0;
            end else begin
               m_pc[u] = sat(m_pc[u] + $countones(ep), cmax[u]);
               m_fc[u] = sat(m_fc[u] + $countones(ef), cmax[u]);
               m_vc[u] = sat(m_vc[u] + $countones(ev), cmax[u]);
               if (m_stk[u] == '0 && ef != '0) m_ffc[u] = lowest(ef);
               m_stk[u] = m_stk[u] | ef;
            end
         end
      end
      if (e < HMAX - 1) e++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("m0_pass", 32'(p0_pass), 32'(m_pass[0]));
      chk("m0_fail", 32'(p0_fail), 32'(m_fail[0]));
      chk("m0_stk",  32'(p0_stk),  32'(m_stk[0]));
      chk("m0_err",  32'(p0_err),  32'(m_stk[0] != '0));
      chk("m0_ffc",  32'(p0_ffc),  m_ffc[0]);
      chk("m0_pc",   32'(p0_pc),   m_pc[0]);
      chk("m0_fc",   32'(p0_fc),   m_fc[0]);
      chk("m0_vc",   32'(p0_vc),   m_vc[0]);
      chk("m1_pass", 32'(p1_pass), 32'(m_pass[1]));
      chk("m1_fail", 32'(p1_fail), 32'(m_fail[1]));
      chk("m1_stk",  32'(p1_stk),  32'(m_stk[1]));
      chk("m1_err",  32'(p1_err),  32'(m_stk[1] != '0));
      chk("m1_ffc",  32'(p1_ffc),  m_ffc[1]);
      chk("m1_pc",   32'(p1_pc),   m_pc[1]);
      chk("m1_fc",   32'(p1_fc),   m_fc[1]);
      chk("m1_vc",   32'(p1_vc),   m_vc[1]);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_p0"}, 32'({p0_pass, p0_fail, p0_stk, p0_err, p0_ffc}), 32'h0);
      chk({tag, "_c0"}, {p0_pc, p0_fc} | 32'(p0_vc), 32'h0);
      chk({tag, "_p1"}, 32'({p1_pass, p1_fail, p1_stk, p1_err, p1_ffc}), 32'h0);
      chk({tag, "_c1"}, 32'({p1_pc, p1_fc, p1_vc}), 32'h0);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic drv(input logic en_i, input logic [NCH-1:0] ab, input logic [NCH-1:0] cc,
                      input logic [NCH-1:0] dd);
      en = en_i; a = ab; b = ab; c = cc; d = dd; clr = 1'b0; rst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drv(1'b1, 4'h0, 4'h0, 4'h0);
         tick();
      end
   endtask

   task automatic clear_step();
      drv(1'b1, 4'h0, 4'h0, 4'h0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; en = 1'b0; a = '0; b = '0; c = '0; d = '0;
      tick();
      tick();
      chk_zero("reset");

      // Basic pass on ch0.
      drv(1'b1, 4'h1, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h1, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h0); tick();
      chk("t1_pass", 32'(p0_pass), 32'h1);
      chk("t1_pc",   32'(p0_pc),   32'h1);
      chk("t1_fc",   32'(p0_fc),   32'h0);
      tick();
      chk("t1_pulse_end", 32'(p0_pass), 32'h0);
      idle(3); clear_step();

      // Basic fail on ch0.
      drv(1'b1, 4'h1, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h1, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h1); tick();
      chk("t2_fail", 32'(p0_fail), 32'h1);
      chk("t2_stk",  32'(p0_stk),  32'h1);
      chk("t2_err",  32'(p0_err),  32'h1);
      chk("t2_ffc",  32'(p0_ffc),  32'h0);
      chk("t2_fc",   32'(p0_fc),   32'h1);
      idle(4); clear_step();

      // Three overlapping attempts on ch0.
      drv(1'b1, 4'h1, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h1, 4'h1, 4'h0); tick();
      drv(1'b1, 4'h1, 4'h1, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h1, 4'h0); tick();
      chk("t3_pass_a", 32'(p0_pass), 32'h1);
      drv(1'b1, 4'h0, 4'h0, 4'h1); tick();
      chk("t3_fail_b", 32'(p0_fail), 32'h1);
      drv(1'b1, 4'h0, 4'h0, 4'h0); tick();
      chk("t3_pass_c", 32'(p0_pass), 32'h1);
      chk("t3_pc",     32'(p0_pc),   32'h2);
      chk("t3_fc",     32'(p0_fc),   32'h1);
      idle(4); clear_step();

      // Vacuous attempt, with d high where a check would have been.
      drv(1'b1, 4'h1, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h0); tick();
      chk("t4_vc", 32'(p0_vc), 32'h1);
      drv(1'b1, 4'h0, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h1); tick();
      chk("t4_no_pulse", 32'({p0_pass, p0_fail}), 32'h0);
      drv(1'b1, 4'h0, 4'h0, 4'h1); tick();
      chk("t4_no_pulse1", 32'({p1_pass, p1_fail}), 32'h0);
      idle(4); clear_step();

      // Non-overlapped instance checks one edge later.
      drv(1'b1, 4'h1, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h1, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h1); tick();
      chk("t4n_fail0", 32'(p0_fail), 32'h1);
      chk("t4n_quiet1", 32'({p1_pass, p1_fail}), 32'h0);
      drv(1'b1, 4'h0, 4'h0, 4'h0); tick();
      chk("t4n_pass1", 32'(p1_pass), 32'h1);
      idle(4); clear_step();

      // Simultaneous fails on ch3 and ch1, then a later ch2 fail.
      drv(1'b1, 4'hA, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'hA, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'hA); tick();
      chk("t5_fail", 32'(p0_fail), 32'hA);
      chk("t5_fc",   32'(p0_fc),   32'h2);
      chk("t5_ffc",  32'(p0_ffc),  32'h1);
      drv(1'b1, 4'h4, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h4, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h4); tick();
      chk("t5_fail2", 32'(p0_fail), 32'h4);
      chk("t5_fc2",   32'(p0_fc),   32'h3);
      chk("t5_ffc2",  32'(p0_ffc),  32'h1);
      chk("t5_stk",   32'(p0_stk),  32'hE);
      idle(4); clear_step();

      // Five passes saturate the 2-bit counter.
      for (int i = 0; i < 5; i++) begin
         drv(1'b1, 4'h1, 4'h1, 4'h0); tick();
      end
      for (int i = 0; i < 5; i++) begin
         drv(1'b1, 4'h0, 4'h1, 4'h0); tick();
      end
      chk("t6_pc16", 32'(p0_pc), 32'h5);
      chk("t6_pc2",  32'(p1_pc), 32'h3);

      // clr on the fail edge: pulse survives, bookkeeping does not.
      drv(1'b1, 4'h1, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h1, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h1); clr = 1'b1; tick();
      chk("t7_fail", 32'(p0_fail), 32'h1);
      chk("t7_fc",   32'(p0_fc),   32'h0);
      chk("t7_err",  32'(p0_err),  32'h0);
      idle(1);

      // rst between start and check discards the attempt.
      drv(1'b1, 4'h1, 4'h0, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h1, 4'h0); tick();
      drv(1'b1, 4'h0, 4'h0, 4'h0); rst = 1'b1; tick();
      chk_zero("t8_rst");
      drv(1'b1, 4'h0, 4'h0, 4'h1); tick();
      chk_zero("t8_after");
      drv(1'b1, 4'h0, 4'h0, 4'h1); tick();
      chk_zero("t8_after1");

      // Random traffic with occasional rst/clr.
      for (int i = 0; i < 400; i++) begin
         en  = ($urandom_range(0, 7) != 0);
         a   = 4'($urandom);
         b   = 4'($urandom);
         c   = 4'($urandom);
         d   = 4'($urandom);
         rst = ($urandom_range(0, 63) == 0);
         clr = ($urandom_range(0, 31) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
